// File: rtl/sap1_alu_datapath.sv
// SAP-1 arithmetic datapath: accumulator, B register, add/subtract ALU and output register
// attached to the shared W bus, which is modelled as separate in/out/oe signals.
module sap1_alu_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             la_n,
  input  logic             ea,
  input  logic             lb_n,
  input  logic             eu,
  input  logic             su,
  input  logic             lo_n,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] alu_q,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] display,
  output logic             bus_conflict
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] b_operand;
  logic [SUM_W-1:0] sum;

  // Registers load the pre-edge bus value, so A <= A +/- B is loop-free.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_q   <= '0;
      b_q     <= '0;
      display <= '0;
    end else begin
      if (!la_n) acc_q   <= bus_in;
      if (!lb_n) b_q     <= bus_in;
      if (!lo_n) display <= bus_in;
    end
  end

  // Subtract as A + ~B + 1, so carry=1 means no borrow.
  always_comb begin
    b_operand = su ? ~b_q : b_q;
    sum       = SUM_W'(acc_q) + SUM_W'(b_operand) + SUM_W'(su);
    alu_q     = sum[WIDTH-1:0];
    carry     = sum[WIDTH];
    zero      = (alu_q == '0);
  end

  // ALU result wins the bus over the accumulator when both are enabled.
  always_comb begin
    bus_out = '0;
    if (eu)      bus_out = alu_q;
    else if (ea) bus_out = acc_q;
    bus_oe       = ea | eu;
    bus_conflict = ea & eu;
  end

endmodule

// File: tb/tb_sap1_alu_datapath.sv
// Directed bench for sap1_alu_datapath: reset, add/subtract, wrap, accumulate loop,
// bus drive priority and register hold.
module tb_sap1_alu_datapath;

  logic       clk;
  logic       clrn;
  logic [7:0] bus_in;
  logic       la_n, ea, lb_n, eu, su, lo_n;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] acc_q, b_q, alu_q, display;
  logic       carry, zero, bus_conflict;

  int vectors;
  int miscompares;

  sap1_alu_datapath #(.WIDTH(8)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .bus_in       (bus_in),
    .la_n         (la_n),
    .ea           (ea),
    .lb_n         (lb_n),
    .eu           (eu),
    .su           (su),
    .lo_n         (lo_n),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .acc_q        (acc_q),
    .b_q          (b_q),
    .alu_q        (alu_q),
    .carry        (carry),
    .zero         (zero),
    .display      (display),
    .bus_conflict (bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ea = 1'b0; eu = 1'b0;
    bus_in = a; la_n = 1'b0; lb_n = 1'b1;
    tick();
    la_n = 1'b1; bus_in = b; lb_n = 1'b0;
    tick();
    lb_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clrn = 1'b1; bus_in = 8'h55; la_n = 1'b0; lb_n = 1'b0; lo_n = 1'b0;
    ea = 1'b0; eu = 1'b0; su = 1'b0;

    // 1: load nonzero values, then assert reset mid-cycle
    tick();
    check("pre_reset_acc", acc_q, 8'h55);
    #2 clrn = 1'b0;
    #1;
    check("rst_acc", acc_q, 8'h00);
    check("rst_b", b_q, 8'h00);
    check("rst_display", display, 8'h00);
    check("rst_alu", alu_q, 8'h00);
    check("rst_zero", zero, 1'b1);
    check("rst_carry_add", carry, 1'b0);
    check("rst_bus_oe", bus_oe, 1'b0);
    su = 1'b1;
    #1;
    check("rst_carry_sub", carry, 1'b1);
    su = 1'b0;
    tick();
    check("rst_load_ignored", acc_q, 8'h00);
    clrn = 1'b1; la_n = 1'b1; lb_n = 1'b1; lo_n = 1'b1;
    tick();

    // 2: basic add / subtract
    load_ab(8'h05, 8'h03);
    check("load_acc", acc_q, 8'h05);
    check("load_b", b_q, 8'h03);
    eu = 1'b1; su = 1'b0;
    #1;
    check("add_bus_out", bus_out, 8'h08);
    check("add_bus_oe", bus_oe, 1'b1);
    check("add_carry", carry, 1'b0);
    su = 1'b1;
    #1;
    check("sub_bus_out", bus_out, 8'h02);
    check("sub_carry", carry, 1'b1);
    check("sub_zero", zero, 1'b0);

    // 3: wrap boundaries
    load_ab(8'h00, 8'h01);
    su = 1'b1;
    #1;
    check("sub_wrap_alu", alu_q, 8'hFF);
    check("sub_wrap_carry", carry, 1'b0);
    check("sub_wrap_zero", zero, 1'b0);
    load_ab(8'hFF, 8'h01);
    su = 1'b0;
    #1;
    check("add_wrap_alu", alu_q, 8'h00);
    check("add_wrap_carry", carry, 1'b1);
    check("add_wrap_zero", zero, 1'b1);

    // 4: accumulate with bus looped back
    load_ab(8'h10, 8'h01);
    su = 1'b0; eu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 bus_in = bus_out;
      la_n = 1'b0;
      tick();
    end
    la_n = 1'b1;
    check("accum_acc", acc_q, 8'h13);

    // 5: bus drive priority and output register
    eu = 1'b0; ea = 1'b1;
    #1;
    check("ea_bus_out", bus_out, 8'h13);
    check("ea_conflict", bus_conflict, 1'b0);
    eu = 1'b1;
    #1;
    check("both_bus_out", bus_out, 8'h14);
    check("both_conflict", bus_conflict, 1'b1);
    ea = 1'b0; eu = 1'b0;
    #1;
    check("idle_bus_out", bus_out, 8'h00);
    check("idle_bus_oe", bus_oe, 1'b0);
    bus_in = 8'h2A; lo_n = 1'b0;
    tick();
    lo_n = 1'b1;
    check("display_load", display, 8'h2A);
    check("display_acc_kept", acc_q, 8'h13);

    // 6: hold with random bus traffic
    for (int i = 0; i < 10; i++) begin
      bus_in = 8'($urandom_range(0, 255));
      su = 1'($urandom_range(0, 1));
      tick();
      check("hold_acc", acc_q, 8'h13);
      check("hold_b", b_q, 8'h01);
      check("hold_display", display, 8'h2A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
